ship_board_mem: RTL

- Responder/storage side of the ship-figure lookup interface used by the board drawer.
- Holds the 8x8 cell state of both boards (host, guest), each cell 2 bits.
- Answers per-pixel cell/line requests with a 48-bit glyph row (24 pixels x 2-bit code) at a fixed 2-cycle latency, which matches the drawer's 2-stage VGA delay.
- Game logic writes cells through a valid/ready update port. A clear engine wipes both boards.

---
 rtl/ship_board_mem_pkg.sv | 51 +++++
 rtl/ship_board_mem_if.sv | 34 +++
 rtl/ship_board_mem_glyph_rom.sv | 32 +++
 rtl/ship_board_mem.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/ship_board_mem_pkg.sv
// Shared types, sizes and glyph geometry for the ship board memory and its glyph ROM.
package ship_pkg;

   localparam int CELLS       = 64;
   localparam int ADDR_W      = $clog2(CELLS);
   localparam int GLYPH_LINES = 32;
   localparam int LINE_W      = $clog2(GLYPH_LINES);
   localparam int GLYPH_W     = 48;
   localparam int GLYPH_PX    = GLYPH_W / 2;
   localparam int HITS_W      = $clog2(CELLS + 1);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      SHIP  = 2'd1,
      HIT   = 2'd2,
      MISS  = 2'd3
   } cell_state_t;

   localparam logic [1:0] PIX_CLEAR = 2'b00;
   localparam logic [1:0] PIX_GREY  = 2'b01;
   localparam logic [1:0] PIX_WHITE = 2'b10;
   localparam logic [1:0] PIX_BLACK = 2'b11;

   localparam int BOX_ROW_LO  = 4;
   localparam int BOX_ROW_HI  = 27;
   localparam int BOX_PX_LO   = 2;
   localparam int BOX_PX_HI   = 21;
   localparam int MISS_ROW_LO = 12;
   localparam int MISS_ROW_HI = 19;
   localparam int MISS_PX_LO  = 8;
   localparam int MISS_PX_HI  = 15;

   // Two-bit code of pixel px (0 = leftmost) on glyph row line for a given cell state.
   function automatic logic [1:0] glyph_pixel(cell_state_t st, logic [LINE_W-1:0] line, int px);
      int   row;
      logic in_box;
      logic in_miss;
      row     = int'(line);
      in_box  = (row >= BOX_ROW_LO) && (row <= BOX_ROW_HI) &&
                (px >= BOX_PX_LO) && (px <= BOX_PX_HI);
      in_miss = (row >= MISS_ROW_LO) && (row <= MISS_ROW_HI) &&
                (px >= MISS_PX_LO) && (px <= MISS_PX_HI);
      case (st)
         SHIP:    glyph_pixel = in_box  ? PIX_GREY  : PIX_CLEAR;
         HIT:     glyph_pixel = in_box  ? PIX_WHITE : PIX_CLEAR;
         MISS:    glyph_pixel = in_miss ? PIX_BLACK : PIX_CLEAR;
         default: glyph_pixel = PIX_CLEAR;
      endcase
   endfunction

endpackage

// File: rtl/ship_board_mem_if.sv
// Drawer lookup, cell update and clear/status signals between the game side and the board memory.
interface ship_board_mem_if;
   import ship_pkg::*;

   logic [ADDR_W-1:0]  ship_xy_host;
   logic [ADDR_W-1:0]  ship_xy_guest;
   logic [LINE_W-1:0]  ship_line;
   logic               board_sel;
   logic [GLYPH_W-1:0] figure_pixels;

   logic               upd_valid;
   logic               upd_ready;
   logic               upd_board;
   logic [ADDR_W-1:0]  upd_addr;
   logic [1:0]         upd_state;

   logic               clear_req;
   logic [HITS_W-1:0]  hits_host;
   logic [HITS_W-1:0]  hits_guest;
   logic               busy;

   modport master (
      output ship_xy_host, ship_xy_guest, ship_line, board_sel,
      output upd_valid, upd_board, upd_addr, upd_state, clear_req,
      input  figure_pixels, upd_ready, hits_host, hits_guest, busy
   );

   modport slave (
      input  ship_xy_host, ship_xy_guest, ship_line, board_sel,
      input  upd_valid, upd_board, upd_addr, upd_state, clear_req,
      output figure_pixels, upd_ready, hits_host, hits_guest, busy
   );

endinterface

// File: rtl/ship_board_mem_glyph_rom.sv
// Glyph ROM forming read stage 2: registers one 48-bit glyph row, forced to zero while blank.
module ship_glyph_rom
   import ship_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               blank,
   input  cell_state_t        state,
   input  logic [LINE_W-1:0]  line,
   output logic [GLYPH_W-1:0] row
);

   logic [GLYPH_W-1:0] row_next;

   genvar gi;
   generate
      for (gi = 0; gi < GLYPH_PX; gi++) begin : g_px
         assign row_next[GLYPH_W-1-2*gi -: 2] = glyph_pixel(state, line, gi);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row <= '0;
      end else if (blank) begin
         row <= '0;
      end else begin
         row <= row_next;
      end
   end

endmodule

// File: rtl/ship_board_mem.sv
// Host/guest 8x8 cell storage with update handshake, clear engine, hit counters and 2-cycle glyph lookup.
// Optional SHIP_FOG_EN: guest SHIP cells render as EMPTY (stored state and counters unchanged).
module ship_board_mem
   import ship_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   ship_board_mem_if.slave  bus
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } fsm_state_t;

   fsm_state_t         state_reg, state_next;
   logic [ADDR_W-1:0]  clr_cnt_reg, clr_cnt_next;
   logic               accept;
   logic               clear_entry;
   logic               clearing;
   cell_state_t        upd_new;
   logic [3:0]         rd_cells;
   logic [2*HITS_W-1:0] hits_all;
   cell_state_t        rd_state;
   cell_state_t        stage1_state_reg;
   logic [LINE_W-1:0]  stage1_line_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= S_CLEAR;
         clr_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         clr_cnt_reg <= clr_cnt_next;
      end
   end

   // A clear request always wins over a same-cycle update.
   always_comb begin
      state_next   = state_reg;
      clr_cnt_next = clr_cnt_reg;
      accept       = 1'b0;
      clear_entry  = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (bus.clear_req) begin
               state_next   = S_CLEAR;
               clr_cnt_next = '0;
               clear_entry  = 1'b1;
            end else begin
               accept = bus.upd_valid;
            end
         end
         S_CLEAR: begin
            if (bus.clear_req) begin
               clr_cnt_next = '0;
               clear_entry  = 1'b1;
            end else if (clr_cnt_reg == ADDR_W'(CELLS - 1)) begin
               state_next   = S_IDLE;
               clr_cnt_next = '0;
            end else begin
               clr_cnt_next = clr_cnt_reg + ADDR_W'(1);
            end
         end
         default: begin
            state_next   = S_CLEAR;
            clr_cnt_next = '0;
         end
      endcase
   end

   assign clearing      = (state_reg == S_CLEAR);
   assign bus.busy      = clearing;
   assign bus.upd_ready = (state_reg == S_IDLE) && !bus.clear_req;
   assign upd_new       = cell_state_t'(bus.upd_state);

   // Board 0 is host, board 1 is guest.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_board
         cell_state_t       mem [CELLS];
         cell_state_t       old_cell;
         logic              wr_en;
         logic [ADDR_W-1:0] rd_addr;
         logic [HITS_W-1:0] hits_reg;

         assign wr_en    = accept && (bus.upd_board == 1'(gi));
         assign old_cell = mem[bus.upd_addr];
         assign rd_addr  = (gi == 0) ? bus.ship_xy_host : bus.ship_xy_guest;
         assign rd_cells[2*gi +: 2]          = mem[rd_addr];
         assign hits_all[gi*HITS_W +: HITS_W] = hits_reg;

         always_ff @(posedge clk) begin
            if (clearing) begin
               mem[clr_cnt_reg] <= EMPTY;
            end else if (wr_en) begin
               mem[bus.upd_addr] <= upd_new;
            end
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               hits_reg <= '0;
            end else if (clear_entry) begin
               hits_reg <= '0;
            end else if (wr_en) begin
               if (upd_new == HIT && old_cell != HIT) begin
                  hits_reg <= hits_reg + HITS_W'(1);
               end else if (upd_new != HIT && old_cell == HIT) begin
                  hits_reg <= hits_reg - HITS_W'(1);
               end
            end
         end
      end
   endgenerate

   assign bus.hits_host  = hits_all[0 +: HITS_W];
   assign bus.hits_guest = hits_all[HITS_W +: HITS_W];

   always_comb begin
      rd_state = cell_state_t'(rd_cells[{bus.board_sel, 1'b0} +: 2]);
`ifdef SHIP_FOG_EN
      if (bus.board_sel && rd_state == SHIP) begin
         rd_state = EMPTY;
      end
`endif
   end

   // Stage 1: cell state sampled before any same-edge write lands.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stage1_state_reg <= EMPTY;
         stage1_line_reg  <= '0;
      end else begin
         stage1_state_reg <= rd_state;
         stage1_line_reg  <= bus.ship_line;
      end
   end

   ship_glyph_rom u_glyph_rom (
      .clk   (clk),
      .rst   (rst),
      .blank (clearing),
      .state (stage1_state_reg),
      .line  (stage1_line_reg),
      .row   (bus.figure_pixels)
   );

endmodule
